// File: rtl/packed_reg_write_arbiter.sv
// Round-robin arbiter that lets NREQ agents perform nibble-masked writes into one
// shared packed register. At most one write is committed per cycle.
module packed_reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter logic [WIDTH*4-1:0] RESET_VALUE = '1,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH*4-1:0]   req_data,
  input  logic [NREQ*WIDTH-1:0]     req_mask,
  output logic [WIDTH-1:0][3:0]     out,
  output logic                      wr_pulse,
  output logic [IDW-1:0]            wr_id
);

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  logic [WIDTH-1:0][3:0] r_out;
  logic [IDW-1:0]        r_ptr;
  logic                  r_pulse;
  logic [IDW-1:0]        r_id;

  logic [WIDTH-1:0][3:0] w_data_arr [NREQ];
  logic [WIDTH-1:0]      w_mask_arr [NREQ];
  logic [WIDTH-1:0][3:0] w_next;
  logic [IDW:0]          w_scan;
  logic [IDW-1:0]        w_gnt_idx;
  logic                  w_found;
  logic                  w_transfer;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_data_arr[gi] = req_data[gi*WIDTH*4 +: WIDTH*4];
    assign w_mask_arr[gi] = req_mask[gi*WIDTH +: WIDTH];
  end

  // Scan upward from the pointer, wrapping, and take the first valid requester.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_scan >= NREQ_W) w_scan = w_scan - NREQ_W;
      if (!w_found && req_valid[w_scan[IDW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_scan[IDW-1:0];
      end
    end
  end

  // Reset and clear both suppress the grant, so a transfer is exactly a visible ready.
  assign w_transfer = w_found & ~reset & ~clear;
  assign req_ready  = w_transfer ? (NREQ'(1) << w_gnt_idx) : '0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_nib
    assign w_next[gi] = w_mask_arr[w_gnt_idx][gi] ? w_data_arr[w_gnt_idx][gi] : r_out[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= RESET_VALUE;
      r_ptr   <= '0;
      r_pulse <= 1'b0;
      r_id    <= '0;
    end else if (clear) begin
      r_out   <= RESET_VALUE;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_transfer;
      if (w_transfer) begin
        r_out <= w_next;
        r_ptr <= (w_gnt_idx == LAST_ID) ? '0 : w_gnt_idx + 1'b1;
        r_id  <= w_gnt_idx;
      end
    end
  end

  assign out      = r_out;
  assign wr_pulse = r_pulse;
  assign wr_id    = r_id;

endmodule

// File: tb/tb_packed_reg_write_arbiter.sv
// Self-checking bench: a reference model pushes expected register/pulse/id into a
// scoreboard queue at each handshake cycle, popped and compared one cycle later.
module tb_packed_reg_write_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    clear;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH*4-1:0] req_data;
  logic [NREQ*WIDTH-1:0]   req_mask;
  logic [WIDTH-1:0][3:0]   out;
  logic                    wr_pulse;
  logic [1:0]              wr_id;

  packed_reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_mask(req_mask),
    .out(out), .wr_pulse(wr_pulse), .wr_id(wr_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] out;
    logic        pulse;
    logic [1:0]  id;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_out;
  int          m_ptr;
  logic        m_pulse;
  logic [1:0]  m_id;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [31:0] d, input logic [7:0] m);
    req_valid[i]          = v;
    req_data[i*32 +: 32]  = d;
    req_mask[i*8 +: 8]    = m;
  endtask

  // Inputs are already applied (posedge+1); check ready, model the edge, check results.
  task automatic step(input string tag);
    int          g;
    logic [3:0]  exp_rdy;
    logic [31:0] d;
    logic [7:0]  m;
    exp_t        e;
    #1;
    g = (reset || clear) ? -1 : model_grant(req_valid, m_ptr);
    exp_rdy = (g < 0) ? 4'b0 : (4'b1 << g);
    chk({tag, ".ready"}, req_ready, exp_rdy);
    if (reset) begin
      m_out = '1; m_ptr = 0; m_pulse = 1'b0; m_id = '0;
    end else if (clear) begin
      m_out = '1; m_pulse = 1'b0;
    end else if (g >= 0) begin
      d = req_data[g*32 +: 32];
      m = req_mask[g*8 +: 8];
      for (int j = 0; j < WIDTH; j++) if (m[j]) m_out[j*4 +: 4] = d[j*4 +: 4];
      m_ptr = (g + 1) % NREQ;
      m_pulse = 1'b1;
      m_id = 2'(g);
    end else begin
      m_pulse = 1'b0;
    end
    sb.push_back('{out: m_out, pulse: m_pulse, id: m_id});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, ".out"}, out, e.out);
    chk({tag, ".pulse"}, wr_pulse, e.pulse);
    chk({tag, ".id"}, wr_id, e.id);
    $display("[%0t] %s valid=%b ready=%b out=%h pulse=%b id=%0d", $time, tag, req_valid,
             exp_rdy, out, wr_pulse, wr_id);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; req_valid = '0; req_data = '0; req_mask = '0;
    m_out = '1; m_ptr = 0; m_pulse = 1'b0; m_id = '0;
    @(posedge clk); #1;
    step("reset"); step("reset");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step("idle");
      chk("idle.out_const", out, 32'hFFFF_FFFF);
    end

    // Single requester 2, low nibbles only
    set_req(2, 1'b1, 32'h1234_5678, 8'h0F);
    #1 chk("r2.ready_const", req_ready, 4'b0100);
    step("r2");
    chk("r2.out_const", out, 32'hFFFF_5678);
    chk("r2.id_const", wr_id, 2);
    set_req(2, 1'b0, 32'h0, 8'h0);
    step("r2.idle");

    // All four requesting from ptr=0
    reset = 1'b1; step("rst2"); reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'(i) * 32'h1111_1111, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      step("rr4");
      chk("rr4.out_const", out, 32'(k % 4) * 32'h1111_1111);
    end

    // Move ptr to 2, then 1 and 3 compete
    req_valid = 4'b0010; step("ptr2");
    req_valid = 4'b1010;
    step("p13.a"); chk("p13.first", wr_id, 3);
    step("p13.b"); chk("p13.second", wr_id, 1);
    req_valid = 4'b1111;
    #1 chk("p13.ptr_end", req_ready, 4'b0100);
    step("p13.c");

    // Clear while requester 0 is valid
    req_valid = 4'b0001; set_req(0, 1'b1, 32'h0, 8'hFF);
    step("zero"); chk("zero.out_const", out, 32'h0);
    clear = 1'b1;
    step("clear"); chk("clear.out_const", out, 32'hFFFF_FFFF);
    clear = 1'b0;
    step("after_clr"); chk("after_clr.id_const", wr_id, 0);

    // All-zero mask still handshakes
    set_req(0, 1'b1, 32'h5555_5555, 8'h00);
    step("mask0"); chk("mask0.pulse_const", wr_pulse, 1'b1);

    // Reset while requester 1 is valid
    req_valid = '0; set_req(1, 1'b1, 32'hAAAA_AAAA, 8'hFF);
    reset = 1'b1; step("rst_mid"); chk("rst_mid.pulse_const", wr_pulse, 1'b0);
    reset = 1'b0; set_req(3, 1'b1, 32'h7777_7777, 8'hFF);
    step("post_rst"); chk("post_rst.id_const", wr_id, 1);
    chk("post_rst.out_const", out, 32'hAAAA_AAAA);

    // Random traffic with occasional clear
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(0, 1)), $urandom, 8'($urandom));
      clear = ($urandom_range(0, 9) == 0);
      step("rand");
    end
    clear = 1'b0; req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/packed_reg_write_arbiter.md
Name: packed_reg_write_arbiter

Overview:
- Shares one packed register of WIDTH 4-bit nibbles (`[WIDTH-1:0][3:0]`, reset to RESET_VALUE) between NREQ requesters.
- Each requester issues nibble-masked writes over a valid/ready handshake.
- A round-robin arbiter commits at most one write per cycle.
- Sits between control agents (config bus, FSMs) and a datapath that consumes the shared register value.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, number of 4-bit nibbles in the shared register.
- RESET_VALUE, -1 (all ones), value loaded into the register on reset or clear; width WIDTH*4.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous reload of RESET_VALUE; takes priority over all writes.
- req_valid  input  NREQ  per-requester write request.
- req_ready  output  NREQ  per-requester grant; combinational, one-hot or zero.
- req_data  input  NREQ*WIDTH*4  write data; requester i occupies bits [i*WIDTH*4 +: WIDTH*4].
- req_mask  input  NREQ*WIDTH  nibble enables; requester i occupies bits [i*WIDTH +: WIDTH]; bit j enables nibble j.
- out  output  WIDTH*4  shared register value, viewed as [WIDTH-1:0][3:0].
- wr_pulse  output  1  registered; high for 1 cycle after each committed write.
- wr_id  output  clog2(NREQ)  registered; index of the requester whose write produced the current out.

Behaviour:
- Reset (reset=1 at posedge):
  - out=RESET_VALUE, rr pointer=0, wr_pulse=0, wr_id=0.
  - req_ready is forced to 0 while reset is high.
  - Reset mid-stream discards any pending request; requesters keep valid asserted and are re-arbitrated from pointer 0.
- Arbitration (combinational, each cycle):
  - Scan req_valid starting at index ptr, upward, wrapping modulo NREQ.
  - The first set index g gets req_ready[g]=1; all other ready bits are 0.
  - If no valid is set, req_ready=0.
- Transfer occurs when req_valid[g] & req_ready[g] at the posedge. Then:
  - For each nibble j: out[j] <= req_mask[g*WIDTH+j] ? req_data nibble j of g : out[j].
  - ptr <= (g+1) mod NREQ.
  - wr_pulse <= 1.
  - wr_id <= g.
- All-zero mask: the transfer still completes (handshake, ptr advance, wr_pulse=1), but out is unchanged.
- No transfer: out holds, ptr holds, wr_pulse <= 0, wr_id holds.
- Clear (clear=1, reset=0):
  - req_ready=0 that cycle; out <= RESET_VALUE; wr_pulse <= 0; ptr and wr_id hold.
  - A requester asserting valid during clear is served in a later cycle.
- Latency:
  - A granted write is visible on out 1 cycle after the handshake cycle.
  - wr_pulse and wr_id update in that same cycle.
- Fairness: a continuously requesting agent waits at most NREQ-1 grants.
- Valid stability: a requester may drop valid without a handshake (no stickiness). Data and mask are sampled only on the handshake cycle.
- Single requester continuously valid: granted every cycle; ptr cycles past it and wraps back to it.

Test Plan:
- Reset release, no requests → out=32'hFFFF_FFFF, req_ready=0, wr_pulse=0 for 10 cycles.
- Requester 2 alone:
  - Stimulus: valid=1, data=32'h1234_5678, mask=8'h0F.
  - Response: req_ready=4'b0100; next cycle out=32'hFFFF_5678, wr_pulse=1, wr_id=2; ptr=3.
- All 4 valid continuously from ptr=0, each with mask=8'hFF and data=i*32'h1111_1111 → grants 0,1,2,3,0,…; out follows 0000_0000, 1111_1111, 2222_2222, 3333_3333, 0000_0000, … one cycle after each grant.
- Requesters 1 and 3 valid with ptr=2 → requester 3 granted first, then 1; ptr ends at 2.
- clear=1 while requester 0 is valid, after out=32'h0 → req_ready=0 that cycle; out=32'hFFFF_FFFF next cycle; requester 0 granted the following cycle.
- reset asserted in a cycle where requester 1 is valid with mask=8'hFF → no write; out=RESET_VALUE, wr_pulse=0, ptr=0; the next grant after release goes to the lowest valid index.
